division_top: RTL and testbench

DIVISION_TOP -- requirements
Module: division_top

---
 rtl/division_pkg.sv | 22 ++
 rtl/subtractor_df.sv | 22 ++
 rtl/division_top.sv | 89 ++++++++
 tb/tb_division_top.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/division_pkg.sv
// division_pkg: shared width constant, FSM state encoding and counter-width helper for the divider.
//   DIV_WIDTH  default operand/result width
//   DIV_CNT_W  iteration counter width for DIV_WIDTH
//   state_t    IDLE / RUN / DONE
package division_pkg;

    localparam int DIV_WIDTH = 64;

    // Counter must hold the value WIDTH itself, hence the +1.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/subtractor_df.sv
// subtractor_df: trial subtraction for one restoring-division step.
//   a_i     WIDTH+1  shifted partial remainder
//   b_i     WIDTH    divisor
//   diff_o  WIDTH+1  a_i - b_i
//   neg_o   1        set when the difference is negative (borrow)
module subtractor_df
    import division_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH:0]   diff_o,
    output logic             neg_o
);

    assign diff_o = a_i - {1'b0, b_i};
    // a_i < 2*b_i always holds in the divider, so the difference lies in
    // (-b_i, b_i) and the top bit is a faithful sign at WIDTH+1 bits.
    assign neg_o  = diff_o[WIDTH];

endmodule

// File: rtl/division_top.sv
// division_top: unsigned restoring divider, one quotient bit per cycle.
//   clk, reset                    clock, async active-high reset
//   start                         request, sampled only while ready
//   dividend_in, divisor_in       operands, captured on an accepted start
//   ready                         high in IDLE/DONE, low while dividing
//   quotient, remainder           result of the last completed operation
//   div_by_zero                   captured divisor was zero
module division_top
    import division_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic             ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH:0]   shifted, diff;
    logic             neg;

    // Remainder gains the quotient MSB; kept at WIDTH+1 bits so nothing is lost.
    assign shifted = {rem_q, quo_q[WIDTH-1]};

    subtractor_df #(.WIDTH(WIDTH)) u_sub (
        .a_i    (shifted),
        .b_i    (dvs_q),
        .diff_o (diff),
        .neg_o  (neg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        dbz_d   = dbz_q;
        if (state_q != RUN && start) begin
            dvs_d   = divisor_in;
            cnt_d   = CW'(WIDTH);
            dbz_d   = divisor_in == '0;
            state_d = dbz_d ? DONE : RUN;
            quo_d   = dbz_d ? '1 : dividend_in;
            rem_d   = dbz_d ? dividend_in : '0;
        end else if (state_q == RUN) begin
            // On a negative trial the shifted remainder is < divisor, so its top bit is 0.
            rem_d   = WIDTH'(neg ? shifted : diff);
            quo_d   = {quo_q[WIDTH-2:0], ~neg};
            cnt_d   = cnt_q - 1'b1;
            state_d = cnt_q == CW'(1) ? DONE : RUN;
        end
    end

    assign ready       = state_q != RUN;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_division_top.sv
// tb_division_top: scoreboard bench for division_top with a reference model using / and %.
module tb_division_top;

    localparam int W = 64;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend_in = '0;
    logic [W-1:0] divisor_in = '0;
    logic         ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    exp_t sb[$];
    int   checks = 0;
    int   fails = 0;
    int   edge_n = 0;
    int   acc_edge = 0;
    bit   inflight = 0;

    division_top #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend_in (dividend_in),
        .divisor_in  (divisor_in),
        .ready       (ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.a   = a;
        e.b   = b;
        e.dbz = b == '0;
        e.q   = e.dbz ? {W{1'b1}} : a / b;
        e.r   = e.dbz ? a : a % b;
        e.lat = e.dbz ? 0 : W;
        return e;
    endfunction

    // Monitor: notes accepted starts, and compares once ready shows a finished result.
    initial forever begin
        @(posedge clk);
        edge_n++;
        if (reset) begin
            sb.delete();
            inflight = 0;
        end else begin
            if (start && ready) begin
                acc_edge = edge_n;
                inflight = 1;
            end
            #1;
            if (inflight && ready) begin
                inflight = 0;
                if (sb.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("quotient", quotient, e.q);
                    chk("remainder", remainder, e.r);
                    chk("div_by_zero", div_by_zero, e.dbz);
                    chk("latency", edge_n - acc_edge, e.lat);
                    if (!e.dbz) begin
                        chk("identity", {{W{1'b0}}, quotient} * {{W{1'b0}}, e.b} + remainder, {{W{1'b0}}, e.a});
                        chk("rem_lt_div", remainder < e.b, 1);
                    end
                end
            end else if (inflight && edge_n - acc_edge > W + 4) begin
                inflight = 0;
                chk("completion_timeout", edge_n - acc_edge, W);
            end
        end
    end

    // Called at a negedge; waits for ready, issues one start, returns at the next negedge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int t = 0;
        while (!ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("ready_timeout", t, 0);
        sb.push_back(model(a, b));
        start = 1'b1;
        dividend_in = a;
        divisor_in = b;
        @(negedge clk);
        start = 1'b0;
        dividend_in = {$urandom, $urandom};
        divisor_in = {$urandom, $urandom};
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb.size() != 0 || inflight || !ready) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_op(100, 7);
        wait_idle();
        run_op(64'h1234, 0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op(5, 9);
        wait_idle();
        repeat (5) @(negedge clk);
        chk("hold_quotient", quotient, 0);
        chk("hold_remainder", remainder, 5);
        chk("hold_ready", ready, 1);

        run_op(1000, 33);
        repeat (9) @(negedge clk);
        start = 1'b1;
        dividend_in = 64'd999_999;
        divisor_in = 64'd2;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        run_op(64'hDEAD_BEEF_0000_1234, 3);
        repeat (29) @(negedge clk);
        chk("busy_ready", ready, 0);
        reset = 1'b1;
        #1;
        chk("abort_ready", ready, 1);
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        chk("abort_dbz", div_by_zero, 0);
        @(negedge clk);
        reset = 1'b0;
        run_op(81, 9);
        wait_idle();

        for (int i = 0; i < 500; i++) begin
            logic [W-1:0] a, b;
            a = {$urandom, $urandom} >> $urandom_range(0, 40);
            b = {$urandom, $urandom} >> $urandom_range(0, 63);
            if (b == '0) b = 1;
            run_op(a, b);
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
